io_byte_responder: RTL and testbench

Responder end of the byte-wide memory bus driven by the CPU memory controller. It serves one byte per request from an internal byte RAM with a fixed one-cycle read latency. It also decodes a small memory-mapped IO window that backs a TX byte stream (program output) and an RX byte stream (program input), plus a halt register. It sits between the memory controller and the board/testbench RAM and UART shim.

---
 rtl/io_byte_pkg.sv | 15 +
 rtl/byte_fifo.sv | 57 +++++
 rtl/io_byte_responder.sv | 115 +++++++++++
 tb/tb_io_byte_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/io_byte_pkg.sv
// io_byte_pkg
//   Shared constants for the byte-bus responder: IO window tag, register
//   offsets inside the IO window and bit positions of the status byte.
package io_byte_pkg;

   localparam logic [1:0] IO_TAG  = 2'b11;   // addr[17:16] of the IO window
   localparam logic [2:0] IO_DATA = 3'd0;    // RX pop on read, TX push on write
   localparam logic [2:0] IO_CTRL = 3'd4;    // status on read, halt on write

   // status byte layout: {5'b0, ovf, rx_nonempty, tx_full}
   localparam int ST_TX_FULL = 0;
   localparam int ST_RX_NE   = 1;
   localparam int ST_OVF     = 2;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
//   Synchronous FIFO, 2^AW entries, AW+1-bit pointers (the extra MSB tells
//   full from empty). A pop and push in the same cycle on a full FIFO both
//   succeed; on an empty FIFO only the push does, and the head shows up on
//   the following cycle. dout reads 0 while empty.
// Ports:
//   clk, rst    clock, async active-high reset (flushes pointers)
//   push, din   write request and data
//   pop, dout   read request and head of queue
//   full, empty occupancy flags
//   count       number of stored entries (0..2^AW)
module byte_fifo #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // a pop frees the slot the push lands in, so full+pop still accepts
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/io_byte_responder.sv
// io_byte_responder
//   Responder for the byte-wide memory bus. Serves reads/writes from an
//   internal byte RAM (one-cycle registered read) and decodes an IO window
//   (addr[17:16] == IO_TAG) holding a TX byte stream, an RX byte stream,
//   a status byte and a sticky halt flag.
// Ports:
//   clk, rst                         clock, async active-high reset
//   mem_valid/mem_a/mem_wr/mem_din   one-beat byte request
//   mem_dout                         registered read data (holds otherwise)
//   io_buffer_full                   TX FIFO at depth-1 or more entries
//   tx_data/tx_valid/tx_ready        TX stream out (head of TX FIFO)
//   rx_data/rx_valid/rx_ready        RX stream in (rx_ready = RX not full)
//   halt                             sticky program-end flag
module io_byte_responder #(
   parameter int         RAM_AW  = 17,
   parameter int         FIFO_AW = 3,
   parameter logic [1:0] IO_TAG  = io_byte_pkg::IO_TAG
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        halt
);

   import io_byte_pkg::*;

   localparam int                 FDEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   ALMOST = (FIFO_AW+1)'(FDEPTH - 1);

   logic [7:0]        ram [2**RAM_AW];
   logic [RAM_AW-1:0] ram_addr;
   logic              io_sel, rd_beat, wr_beat, ram_we;
   logic [2:0]        io_off;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic              rx_push, rx_pop, rx_full, rx_empty;
   logic [FIFO_AW:0]  tx_cnt, rx_cnt;
   logic [7:0]        rx_head, status;
   logic              ovf;
   logic              unused_ok;

   assign io_sel   = (mem_a[17:16] == IO_TAG);
   assign io_off   = mem_a[2:0];
   assign ram_addr = mem_a[RAM_AW-1:0];
   assign rd_beat  = mem_valid && !mem_wr;
   assign wr_beat  = mem_valid &&  mem_wr;
   assign ram_we   = wr_beat && !io_sel;

   assign tx_push = wr_beat && io_sel && (io_off == IO_DATA);
   assign tx_pop  = tx_valid && tx_ready;
   assign rx_pop  = rd_beat && io_sel && (io_off == IO_DATA);
   assign rx_push = rx_valid && rx_ready;

   byte_fifo #(.DW(8), .AW(FIFO_AW)) u_tx (
      .clk(clk), .rst(rst), .push(tx_push), .din(mem_din), .pop(tx_pop),
      .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
   );

   byte_fifo #(.DW(8), .AW(FIFO_AW)) u_rx (
      .clk(clk), .rst(rst), .push(rx_push), .din(rx_data), .pop(rx_pop),
      .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
   );

   assign tx_valid       = !tx_empty;
   assign io_buffer_full = (tx_cnt >= ALMOST);
   assign rx_ready       = !rx_full;

   always_comb begin
      status             = '0;
      status[ST_TX_FULL] = tx_full;
      status[ST_RX_NE]   = !rx_empty;
      status[ST_OVF]     = ovf;
   end

   // RAM array has no reset; the !rst term drops a write beat that lands
   // on the same edge as reset assertion
   always_ff @(posedge clk) begin
      if (ram_we && !rst) ram[ram_addr] <= mem_din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_dout <= '0;
         ovf      <= 1'b0;
         halt     <= 1'b0;
      end else begin
         // overflow only when the TX FIFO stays full through this edge
         if (tx_push && tx_full && !tx_pop) ovf <= 1'b1;
         if (wr_beat && io_sel && (io_off == IO_CTRL)) halt <= 1'b1;
         if (rd_beat) begin
            if (!io_sel) mem_dout <= ram[ram_addr];
            else begin
               case (io_off)
                  IO_DATA: mem_dout <= rx_head;   // 0 when RX empty
                  IO_CTRL: mem_dout <= status;
                  default: mem_dout <= 8'h00;
               endcase
            end
         end
      end
   end

   assign unused_ok = ^{mem_a, rx_cnt};

endmodule

// File: tb/tb_io_byte_responder.sv
module tb_io_byte_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_wr, tx_ready, rx_valid;
   logic [31:0] mem_a;
   logic [7:0]  mem_din, mem_dout, tx_data, rx_data;
   logic        io_buffer_full, tx_valid, rx_ready, halt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   io_byte_responder dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_a(mem_a),
      .mem_wr(mem_wr), .mem_din(mem_din), .mem_dout(mem_dout),
      .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .halt(halt)
   );

   // reference model: RAM as a sparse map, FIFOs as queues of bytes
   logic [7:0] m_ram [int];
   logic [7:0] txq [$];
   logic [7:0] rxq [$];
   logic       m_ovf, m_halt;
   logic [7:0] m_dout;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      txq.delete();
      rxq.delete();
      m_ovf  = 1'b0;
      m_halt = 1'b0;
      m_dout = 8'h00;
   endtask

   task automatic check_all();
      chk("mem_dout", mem_dout, m_dout);
      chk("tx_valid", tx_valid, txq.size() != 0);
      chk("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
      chk("io_buffer_full", io_buffer_full, txq.size() >= 7);
      chk("rx_ready", rx_ready, rxq.size() < 8);
      chk("halt", halt, m_halt);
   endtask

   // apply the current inputs to the model, clock once, compare
   task automatic step();
      logic [7:0] st;
      bit         txp, rxp;
      int         ri;
      st  = {5'b0, m_ovf, rxq.size() != 0, txq.size() == 8};
      txp = tx_ready && (txq.size() != 0);
      rxp = rx_valid && (rxq.size() < 8);
      if (txp) void'(txq.pop_front());
      if (mem_valid) begin
         if (mem_a[17:16] != 2'b11) begin
            ri = int'(mem_a[16:0]);
            if (mem_wr) m_ram[ri] = mem_din;
            else        m_dout = m_ram[ri];
         end else begin
            case (mem_a[2:0])
               3'd0: if (mem_wr) begin
                        if (txq.size() < 8) txq.push_back(mem_din);
                        else m_ovf = 1'b1;
                     end else m_dout = (rxq.size() != 0) ? rxq.pop_front() : 8'h00;
               3'd4: if (mem_wr) m_halt = 1'b1; else m_dout = st;
               default: if (!mem_wr) m_dout = 8'h00;
            endcase
         end
      end
      if (rxp) rxq.push_back(rx_data);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic beat(input bit wr, input logic [31:0] a, input logic [7:0] d);
      mem_valid = 1'b1;
      mem_wr    = wr;
      mem_a     = a;
      mem_din   = d;
      step();
      mem_valid = 1'b0;
      mem_wr    = 1'b0;
   endtask

   initial begin
      logic [31:0] r, r2;
      logic [7:0]  old5;
      rst = 1'b1; mem_valid = 0; mem_wr = 0; mem_a = 0; mem_din = 0;
      tx_ready = 0; rx_valid = 0; rx_data = 0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_mem_dout", mem_dout, 8'h00);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_halt", halt, 1'b0);
      chk("rst_buf_full", io_buffer_full, 1'b0);
      chk("rst_rx_ready", rx_ready, 1'b1);
      rst = 1'b0;

      // RAM write then read next cycle; idle cycle holds data
      beat(1, 32'h0001_0010 & 32'h0000_0010, 8'hA5);
      beat(0, 32'h0000_0010, 8'h00);
      chk("ram_rd_a5", mem_dout, 8'hA5);
      step();
      chk("dout_hold", mem_dout, 8'hA5);

      // prefill the RAM windows used by the random phase
      for (int i = 0; i < 16; i++) begin
         r = $urandom;
         beat(1, 32'(i), r[7:0]);
         beat(1, 32'h0001_0000 + 32'(i), r[15:8]);
      end

      // TX fill with sink stalled
      for (int i = 0; i < 8; i++) begin
         beat(1, 32'h0003_0000, 8'h41 + 8'(i));
         chk("buf_full_rise", io_buffer_full, i >= 6);
      end
      beat(1, 32'h0003_0000, 8'h50);
      beat(0, 32'h0003_0004, 8'h00);
      chk("status_ovf", mem_dout, 8'h05);

      // full FIFO: pop and push in the same cycle
      tx_ready = 1'b1;
      beat(1, 32'h0003_0000, 8'h49);
      tx_ready = 1'b0;
      chk("full_swap_bf", io_buffer_full, 1'b1);
      beat(0, 32'h0003_0004, 8'h00);
      chk("full_swap_status", mem_dout, 8'h05);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("drain_order", tx_data, 8'h42 + 8'(i));
         step();
      end
      chk("drain_empty", tx_valid, 1'b0);
      tx_ready = 1'b0;

      // RX stream
      rx_valid = 1'b1; rx_data = 8'h10; step();
      rx_data = 8'h20; step();
      rx_valid = 1'b0;
      beat(0, 32'h0003_0004, 8'h00); chk("rx_ne0", mem_dout[1], 1'b1);
      beat(0, 32'h0003_0000, 8'h00); chk("rx_rd0", mem_dout, 8'h10);
      beat(0, 32'h0003_0004, 8'h00); chk("rx_ne1", mem_dout[1], 1'b1);
      beat(0, 32'h0003_0000, 8'h00); chk("rx_rd1", mem_dout, 8'h20);
      beat(0, 32'h0003_0004, 8'h00); chk("rx_ne2", mem_dout[1], 1'b0);
      beat(0, 32'h0003_0000, 8'h00); chk("rx_rd_empty", mem_dout, 8'h00);

      // halt is sticky
      beat(1, 32'h0003_0004, 8'h00);
      chk("halt_set", halt, 1'b1);
      beat(0, 32'h0000_0003, 8'h00);
      beat(1, 32'h0003_0001, 8'h77);
      chk("halt_sticky", halt, 1'b1);

      // load both FIFOs, then assert reset mid-cycle over a RAM write beat
      rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         r = $urandom;
         rx_data = r[7:0];
         if (i < 7) beat(1, 32'h0003_0000, r[15:8]); else step();
      end
      rx_valid = 1'b0;
      chk("pre_rst_bf", io_buffer_full, 1'b1);
      chk("pre_rst_rx_ready", rx_ready, 1'b0);
      old5 = m_ram[5];
      mem_valid = 1'b1; mem_wr = 1'b1; mem_a = 32'h5; mem_din = ~old5;
      #3 rst = 1'b1;
      #1;
      chk("async_halt", halt, 1'b0);
      chk("async_tx_valid", tx_valid, 1'b0);
      chk("async_bf", io_buffer_full, 1'b0);
      chk("async_rx_ready", rx_ready, 1'b1);
      @(posedge clk); #1;
      mem_valid = 1'b0; mem_wr = 1'b0;
      #2 rst = 1'b0;
      model_reset();
      step();
      beat(0, 32'h5, 8'h00);
      chk("rst_write_dropped", mem_dout, old5);

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         r  = $urandom;
         r2 = $urandom;
         tx_ready  = r[0];
         rx_valid  = r[1];
         rx_data   = r[15:8];
         mem_valid = r[2];
         mem_wr    = r[3];
         mem_din   = r[23:16];
         case (r[6:4] % 3'd6)
            3'd0, 3'd1: mem_a = {r2[31:18], 2'(r2[17:16] % 2'd3), 12'h000, r2[3:0]};
            3'd2, 3'd3: mem_a = {r2[31:18], 2'b11, r2[15:3], 3'd0};
            3'd4:       mem_a = {r2[31:18], 2'b11, r2[15:3], (r[24] && r[25]) ? 3'd4 : 3'd0};
            default:    mem_a = {r2[31:18], 2'b11, r2[15:3], r2[2:0]};
         endcase
         step();
      end
      mem_valid = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
